// File: rtl/ntt_bf_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ntt_pkg
// Description : Mode tags, default field parameters and modular helpers
//               shared by the NTT butterfly pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  typedef enum logic [1:0] {
    MODE_CT  = 2'b00,
    MODE_GS  = 2'b01,
    MODE_PWM = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 14;
  localparam int unsigned DEF_Q          = 12289;

  // Single conditional correction: exact for operands already in [0,q).
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    logic [31:0] s;
    s = a + b;
    if (s >= q) s = s - q;
    return s;
  endfunction

  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q);
    return (a >= b) ? (a - b) : (a + q - b);
  endfunction

  // Division by two in the field; odd values borrow one q to become even.
  function automatic logic [31:0] half_q(input logic [31:0] x, input logic [31:0] q);
    return x[0] ? ((x + q) >> 1) : (x >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_bf_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface   : ntt_bf_pipe_if
// Description : Issue and result bundle of the butterfly pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface ntt_bf_pipe_if
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  en;
  logic                  in_valid;
  mode_e                 mode;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] w;
  logic                  out_valid;
  mode_e                 out_mode;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic                  busy;

  modport master (
    output en, in_valid, mode, u, v, w,
    input  out_valid, out_mode, out_a, out_b, busy
  );

  modport slave (
    input  en, in_valid, mode, u, v, w,
    output out_valid, out_mode, out_a, out_b, busy
  );

endinterface
`default_nettype wire

// File: rtl/ntt_bf_pipe_modmul.sv
`default_nettype none
// ============================================================================
// Module      : ntt_modmul
// Description : Barrett modular multiplier, (a*b) mod Q, MUL_LAT stall-able stages.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_modmul
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned Q          = DEF_Q,
  parameter int unsigned MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p
);

  localparam int unsigned K     = 2 * DATA_WIDTH;
  localparam logic [63:0] BAR_M = (64'd1 << K) / 64'(Q);

  logic [63:0]           w_prod;
  logic [127:0]          w_t;
  logic [63:0]           w_qest;
  logic [63:0]           w_r0;
  logic [63:0]           w_r1;
  logic [63:0]           w_r2;
  logic [DATA_WIDTH-1:0] r_pipe [MUL_LAT];

  // The quotient estimate undershoots by at most two, hence two corrections.
  always_comb begin
    w_prod = 64'(a) * 64'(b);
    w_t    = 128'(w_prod) * 128'(BAR_M);
    w_qest = 64'(w_t >> K);
    w_r0   = w_prod - w_qest * 64'(Q);
    w_r1   = (w_r0 >= 64'(Q)) ? (w_r0 - 64'(Q)) : w_r0;
    w_r2   = (w_r1 >= 64'(Q)) ? (w_r1 - 64'(Q)) : w_r1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
    end else if (en) begin
      r_pipe[0] <= DATA_WIDTH'(w_r2);
      for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign p = r_pipe[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/ntt_bf_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ntt_bf_pipe
// Description : Runtime-twiddle CT/GS/PWM/bypass butterfly, fixed MUL_LAT+3 latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_bf_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned Q          = DEF_Q,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic          clk,
  input  logic          rst,
  ntt_bf_pipe_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    mode_e                 mode;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] v;
  } side_t;

  logic                  r_s1_valid;
  mode_e                 r_s1_mode;
  logic [DATA_WIDTH-1:0] r_s1_u;
  logic [DATA_WIDTH-1:0] r_s1_v;
  logic [DATA_WIDTH-1:0] r_s1_w;

  side_t                 r_s2;
  logic [DATA_WIDTH-1:0] r_s2_op;
  logic [DATA_WIDTH-1:0] r_s2_w;
  logic [DATA_WIDTH-1:0] w_s2_a;
  logic [DATA_WIDTH-1:0] w_s2_op;

  side_t                 r_line [MUL_LAT];
  side_t                 w_tail;
  logic [DATA_WIDTH-1:0] w_p;

  logic                  r_s3_valid;
  mode_e                 r_s3_mode;
  logic [DATA_WIDTH-1:0] r_s3_a;
  logic [DATA_WIDTH-1:0] r_s3_b;
  logic [DATA_WIDTH-1:0] w_res_a;
  logic [DATA_WIDTH-1:0] w_res_b;

  logic                  r_out_valid;
  mode_e                 r_out_mode;
  logic [DATA_WIDTH-1:0] r_out_a;
  logic [DATA_WIDTH-1:0] r_out_b;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_inc;
  logic                  w_dec;

  // GS folds the sum/difference here so every mode meets the multiplier at S2.
  always_comb begin
    w_s2_a  = r_s1_u;
    w_s2_op = r_s1_v;
    case (r_s1_mode)
      MODE_GS: begin
        w_s2_a  = DATA_WIDTH'(mod_add(32'(r_s1_u), 32'(r_s1_v), 32'(Q)));
        w_s2_op = DATA_WIDTH'(mod_sub(32'(r_s1_u), 32'(r_s1_v), 32'(Q)));
      end
      MODE_BYP: w_s2_op = '0;
      default:  ;
    endcase
  end

  ntt_modmul #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q),
    .MUL_LAT    (MUL_LAT)
  ) u_modmul (
    .clk (clk),
    .rst (rst),
    .en  (bus.en),
    .a   (r_s2_op),
    .b   (r_s2_w),
    .p   (w_p)
  );

  assign w_tail = r_line[MUL_LAT-1];

  always_comb begin
    w_res_a = w_tail.a;
    w_res_b = w_p;
    case (w_tail.mode)
      MODE_CT: begin
        w_res_a = DATA_WIDTH'(mod_add(32'(w_tail.a), 32'(w_p), 32'(Q)));
        w_res_b = DATA_WIDTH'(mod_sub(32'(w_tail.a), 32'(w_p), 32'(Q)));
      end
      MODE_GS: begin
        w_res_a = DATA_WIDTH'(half_q(32'(w_tail.a), 32'(Q)));
        w_res_b = DATA_WIDTH'(half_q(32'(w_p), 32'(Q)));
      end
      MODE_BYP: w_res_b = w_tail.v;
      default:  ;
    endcase
  end

  assign w_inc = bus.en & bus.in_valid;
  assign w_dec = bus.en & r_s3_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_CT;
      r_s1_u      <= '0;
      r_s1_v      <= '0;
      r_s1_w      <= '0;
      r_s2        <= '0;
      r_s2_op     <= '0;
      r_s2_w      <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_line[i] <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_mode   <= MODE_CT;
      r_s3_a      <= '0;
      r_s3_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_mode  <= MODE_CT;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_cnt       <= '0;
    end else if (bus.en) begin
      r_s1_valid <= bus.in_valid;
      r_s1_mode  <= bus.mode;
      r_s1_u     <= bus.u;
      r_s1_v     <= bus.v;
      r_s1_w     <= bus.w;

      r_s2.valid <= r_s1_valid;
      r_s2.mode  <= r_s1_mode;
      r_s2.a     <= w_s2_a;
      r_s2.v     <= r_s1_v;
      r_s2_op    <= w_s2_op;
      r_s2_w     <= r_s1_w;

      r_line[0] <= r_s2;
      for (int i = 1; i < MUL_LAT; i++) r_line[i] <= r_line[i-1];

      r_s3_valid <= w_tail.valid;
      r_s3_mode  <= w_tail.mode;
      r_s3_a     <= w_res_a;
      r_s3_b     <= w_res_b;

      // Result registers keep the last token when no new one arrives.
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_mode <= r_s3_mode;
        r_out_a    <= r_s3_a;
        r_out_b    <= r_s3_b;
      end

      r_cnt <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_mode  = r_out_mode;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.busy      = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_ntt_bf_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_bf_pipe
// Description : Scoreboard bench for ntt_bf_pipe with a field-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_bf_pipe;
  import ntt_pkg::*;

  localparam int unsigned DW   = 14;
  localparam int unsigned Q    = 12289;
  localparam int unsigned ML   = 4;
  localparam int unsigned L    = ML + 3;
  localparam int unsigned HALF = (Q + 1) / 2;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    mode_e         mode;
    int            stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic e_en = 1'b0;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   adv   = 0;

  ntt_bf_pipe_if #(.DATA_WIDTH(DW)) bus ();

  ntt_bf_pipe #(
    .DATA_WIDTH (DW),
    .Q          (Q),
    .MUL_LAT    (ML),
    .CNT_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e_en <= bus.en;

  // Field semantics: halving is multiplication by the inverse of two.
  function automatic exp_t model(input mode_e m, input int unsigned u, input int unsigned v,
                                 input int unsigned w);
    exp_t e;
    int unsigned p, s, d;
    e.mode  = m;
    e.stamp = 0;
    case (m)
      MODE_CT: begin
        p   = (v * w) % Q;
        e.a = DW'((u + p) % Q);
        e.b = DW'((u + Q - p) % Q);
      end
      MODE_GS: begin
        s   = (u + v) % Q;
        d   = (u + Q - v) % Q;
        p   = (d * w) % Q;
        e.a = DW'((s * HALF) % Q);
        e.b = DW'((p * HALF) % Q);
      end
      MODE_PWM: begin
        e.a = DW'(u);
        e.b = DW'((v * w) % Q);
      end
      default: begin
        e.a = DW'(u);
        e.b = DW'(v);
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input logic en_i, input logic iv_i, input mode_e m, input int unsigned u,
                      input int unsigned v, input int unsigned w, input bit fixed,
                      input int unsigned ea, input int unsigned eb);
    exp_t e;
    bus.en       = en_i;
    bus.in_valid = iv_i;
    bus.mode     = m;
    bus.u        = DW'(u);
    bus.v        = DW'(v);
    bus.w        = DW'(w);
    @(posedge clk);
    if (en_i && iv_i && rst) begin
      e = model(m, u, v, w);
      if (fixed) begin
        e.a = DW'(ea);
        e.b = DW'(eb);
      end
      e.stamp = adv + 1;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic issue_fixed(input mode_e m, input int unsigned u, input int unsigned v,
                             input int unsigned w, input int unsigned ea, input int unsigned eb);
    step(1'b1, 1'b1, m, u, v, w, 1'b1, ea, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, MODE_CT, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_a"}, int'(bus.out_a), 0);
    chk({tag, "_out_b"}, int'(bus.out_b), 0);
    chk({tag, "_out_mode"}, int'(bus.out_mode), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Monitor: a result is new only when the edge that produced it advanced.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (e_en) begin
          adv++;
          if (bus.out_valid) begin
            if (sb.size() == 0) begin
              chk("unexpected_result", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("out_a", int'(bus.out_a), int'(e.a));
              chk("out_b", int'(bus.out_b), int'(e.b));
              chk("out_mode", int'(bus.out_mode), int'(e.mode));
              chk("latency", adv - e.stamp, int'(L));
            end
          end
        end
        chk("busy", int'(bus.busy), int'(sb.size() != 0));
      end
    end
  end

  initial begin
    int  issued;
    bit  seen;
    logic r_e, r_iv;

    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode     = MODE_CT;
    bus.u        = '0;
    bus.v        = '0;
    bus.w        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b1;

    issue_fixed(MODE_CT, 5, 3, 2, 11, 12288);
    idle(9);

    issue_fixed(MODE_GS, 5, 3, 4, 4, 4);
    issue_fixed(MODE_GS, 0, 1, 1, 6145, 6144);
    idle(9);

    issue_fixed(MODE_PWM, 7, 100, 200, 7, 7711);
    issue_fixed(MODE_BYP, 9, 10, 1234, 9, 10);
    idle(9);

    // Three frozen cycles mid-flight stretch the latency to ten edges.
    issue_fixed(MODE_CT, 5, 3, 2, 11, 12288);
    seen = 1'b0;
    for (int i = 1; i <= 14 && !seen; i++) begin
      if (i >= 3 && i <= 5) step(1'b0, 1'b1, MODE_PWM, 1, 2, 3, 1'b0, 0, 0);
      else                  step(1'b1, 1'b0, MODE_CT, 0, 0, 0, 1'b0, 0, 0);
      if (bus.out_valid) begin
        seen = 1'b1;
        chk("stall_latency", i, 10);
      end
    end
    if (!seen) chk("stall_result_seen", 0, 1);
    idle(3);

    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, mode_e'(i), $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
           $urandom_range(Q - 1, 0), 1'b0, 0, 0);
    rst = 1'b0;
    sb.delete();
    #1;
    chk_cleared("midreset");
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("midreset_hold");
    rst = 1'b1;
    idle(10);
    issue_fixed(MODE_CT, 5, 3, 2, 11, 12288);
    idle(9);

    issued = 0;
    while (issued < 10000) begin
      r_e  = ($urandom_range(3, 0) != 0);
      r_iv = ($urandom_range(3, 0) != 0);
      step(r_e, r_iv, mode_e'($urandom_range(3, 0)), $urandom_range(Q - 1, 0),
           $urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0), 1'b0, 0, 0);
      if (r_e && r_iv) issued++;
    end
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    chk("drain_empty", sb.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_bf_pipe.md
Name: ntt_bf_pipe

Overview:
- Parametrised successor to the fixed-twiddle 14-bit butterfly PE.
- Runtime twiddle input, per-token mode tag (CT-NTT, GS-INTT with halving, pointwise multiply, bypass), valid pipeline with global stall, and an in-flight counter.
- Sits between the memory bank/twiddle ROM readers and the writeback path of the NTT core.
- All modes share one multiplier and have identical latency, so tokens of different modes may issue back-to-back.

Parameters:
- DATA_WIDTH, 14, coefficient width; must satisfy Q < 2^DATA_WIDTH.
- Q, 12289, prime modulus; odd.
- MUL_LAT, 4, pipeline depth of the modular multiplier in cycles; legal range is 1 or more.
- CNT_W, 4, width of the occupancy counter; must satisfy 2^CNT_W > MUL_LAT+3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance; 0 freezes every stage, including the multiplier.
- in_valid  in  1  u, v, w and mode are valid this cycle; sampled only when en=1.
- mode  in  2  00=CT, 01=GS, 10=PWM, 11=BYPASS.
- u  in  DATA_WIDTH  upper operand, in range [0,Q).
- v  in  DATA_WIDTH  lower operand, in range [0,Q).
- w  in  DATA_WIDTH  twiddle or pointwise factor, in range [0,Q).
- out_valid  out  1  result valid.
- out_mode  out  2  mode tag carried with the result.
- out_a  out  DATA_WIDTH  first result.
- out_b  out  DATA_WIDTH  second result.
- busy  out  1  high while at least one token is in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - All valid bits, mode tags, data registers, outputs and the counter clear to 0.
  - Tokens in flight are discarded and never emerge.
  - First legal issue is the first edge after rst deasserts.
- Latency: L = MUL_LAT+3 advancing cycles, for every mode.
  - A token sampled at edge t (en=1) appears with out_valid=1 after edge t+L.
  - Cycles with en=0 stretch this 1:1.
- Stage S1: register u, v, w, mode and valid.
- Stage S2:
  - CT, PWM, BYPASS: delay register.
  - GS: registered s = (u+v) mod Q and d = (u−v) mod Q; w is delayed one stage to align with d.
- Multiplier input is taken at the S2 output for every mode, so no structural hazard exists.
  - Operand is v for CT and PWM, d for GS, and 0 for BYPASS.
  - The product is (operand·w) mod Q with MUL_LAT stages.
- Side data (u or s, original v, mode, valid) travels in a MUL_LAT-deep shift line beside the multiplier.
- Final stage: output registers load according to mode (p = product):
  - CT: out_a = (u+p) mod Q, out_b = (u−p) mod Q.
  - GS: out_a = half(s), out_b = half(p).
  - PWM: out_a = u, out_b = p.
  - BYPASS: out_a = u, out_b = v.
- half(x) = x>>1 if x is even, else (x+Q)>>1; the result is always in [0,Q).
- Modular add/sub use a single conditional correction; results are always in [0,Q) for in-range inputs. Out-of-range inputs give undefined results but must not hang.
- out_a, out_b and out_mode hold their last values when out_valid=0; they update only on a valid token.
- en=0 behaviour:
  - No register changes and the counter holds.
  - out_valid holds its current value; the consumer must treat a held valid as one result.
  - in_valid is ignored.
- Occupancy counter (cnt):
  - +1 on an accepted token; −1 when a token leaves the final stage (out_valid rising edge or a repeat valid).
  - Both events in the same cycle leave cnt unchanged.
  - busy = (cnt != 0).
  - Saturation cannot occur given the CNT_W rule.
- Back-to-back issue: one token per advancing cycle, with any mix of modes. Full throughput, no bubbles.

Decomposition:
- Shared package ntt_pkg holds:
  - the mode encodings MODE_CT, MODE_GS, MODE_PWM, MODE_BYP;
  - the default Q and DATA_WIDTH;
  - the halving and modular add/sub functions.
- One sub-module is natural: ntt_modmul.
  - Parametrised by DATA_WIDTH, Q and MUL_LAT.
  - Has an en input and takes a runtime multiplicand.
  - Implementation is Barrett or Plantard internally; only the latency contract is fixed.

Test Plan:
- CT, u=5, v=3, w=2 -> after L=7 cycles: out_a=11, out_b=12288, out_mode=00; busy high for 7 cycles.
- GS, u=5, v=3, w=4 -> out_a=4, out_b=4; GS, u=0, v=1, w=1 -> out_a=6145, out_b=6144.
- PWM u=7, v=100, w=200 then BYPASS u=9, v=10 on consecutive cycles -> results on consecutive cycles:
  - first: out_a=7, out_b=7711;
  - second: out_a=9, out_b=10, out_mode=11.
- Stall: issue CT u=5, v=3, w=2; hold en=0 for 3 cycles mid-flight -> result appears after 10 cycles with the same values; cnt stays at 1 throughout.
- Reset mid-flight: issue 4 tokens, assert rst at cycle 3 -> out_valid never rises for them; busy=0; outputs=0; a new token after release completes normally.
- Random sweep: 10k mixed-mode tokens against a golden model, with random en and Q=12289 operands -> exact match, in-order delivery, busy matches the model count.
